// File: rtl/branch_pkg.sv
// Shared constants for the branch predict unit: next-PC select codes,
// branch funct3 codes, RUN/HALT state and the branch-direction resolver.
package branch_pkg;

  localparam logic [2:0] SEL_HOLD  = 3'b000;
  localparam logic [2:0] SEL_JALR  = 3'b001;
  localparam logic [2:0] SEL_SEQ   = 3'b010;
  localparam logic [2:0] SEL_EXTGT = 3'b011;
  localparam logic [2:0] SEL_PRED  = 3'b100;
  localparam logic [2:0] SEL_RECOV = 3'b101;

  localparam logic [2:0] F_BEQ  = 3'b000;
  localparam logic [2:0] F_BNE  = 3'b001;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_BGE  = 3'b101;
  localparam logic [2:0] F_BLTU = 3'b110;
  localparam logic [2:0] F_BGEU = 3'b111;

  localparam logic [2:0] HALT_EBREAK = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Flags come from rs1 - rs2; carry=1 means no borrow.
  function automatic logic br_resolve(
    input logic [2:0] f,
    input logic       c,
    input logic       z,
    input logic       o,
    input logic       s
  );
    logic t;
    t = 1'b0;
    case (f)
      F_BEQ:   t = z;
      F_BNE:   t = !z;
      F_BLT:   t = (s != o);
      F_BGE:   t = (s == o);
      F_BLTU:  t = !c;
      F_BGEU:  t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bundle between the pipeline (master) and the branch predict unit (slave):
// fetch/EX branch info and ALU flags in; prediction, PC select, stats out.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_branch;
  logic             ex_jal;
  logic             ex_jalr;
  logic [2:0]       ex_funct;
  logic             ex_pred_taken;
  logic             carry;
  logic             zero;
  logic             over;
  logic             sign;
  logic [2:0]       halt;
  logic             resume;
  logic             stat_clr;
  logic [2:0]       pc_sel;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output if_valid, if_pc,
    output ex_valid, ex_pc, ex_branch,
    output ex_jal, ex_jalr, ex_funct,
    output ex_pred_taken,
    output carry, zero, over, sign,
    output halt, resume, stat_clr,
    input  pred_taken, pc_sel, flush,
    input  halted, br_count, mp_count
  );

  modport slave (
    input  if_valid, if_pc,
    input  ex_valid, ex_pc, ex_branch,
    input  ex_jal, ex_jalr, ex_funct,
    input  ex_pred_taken,
    input  carry, zero, over, sign,
    input  halt, resume, stat_clr,
    output pred_taken, pc_sel, flush,
    output halted, br_count, mp_count
  );

endinterface

// File: rtl/bht_table.sv
// Table of 2-bit saturating direction counters; async read, sync write.
// Ports: clk, rst_n, rd_idx -> rd_taken, wr_en/wr_idx/wr_taken.
module bht_table #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] cnt [ENTRIES];

  assign rd_taken = cnt[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        cnt[i] <= 2'b01;
    end else if (wr_en) begin
      if (wr_taken && cnt[wr_idx] != 2'b11)
        cnt[wr_idx] <= cnt[wr_idx] + 2'd1;
      else if (!wr_taken && cnt[wr_idx] != 2'b00)
        cnt[wr_idx] <= cnt[wr_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve/predict: BHT lookup at fetch, EX resolution, next-PC
// priority, EBREAK halt FSM and saturating branch/mispredict counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  state_t           state;
  logic             run;
  logic             taken;
  logic             ex_br;
  logic             bht_we;
  logic             mp;
  logic             halt_go;
  logic             pred;
  logic [2:0]       sel;
  logic             fl;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mp_q;
  logic [XLEN-1:0]  fpc;
  logic [XLEN-1:0]  xpc;
  logic             unused_pc;

  assign fpc = bus.if_pc;
  assign xpc = bus.ex_pc;
  assign unused_pc = ^{fpc[XLEN-1:IDX_W+2], fpc[1:0],
                       xpc[XLEN-1:IDX_W+2], xpc[1:0]};

  assign run   = (state == ST_RUN);
  assign taken = br_resolve(bus.ex_funct, bus.carry,
                            bus.zero, bus.over, bus.sign);
  assign ex_br  = bus.ex_valid & bus.ex_branch;
  assign bht_we = run & ex_br;

  // Only counts when the branch, not a jump, wins the priority.
  assign mp = bht_we & !bus.ex_jalr & !bus.ex_jal
            & (taken != bus.ex_pred_taken);

  assign halt_go = run & bus.ex_valid
                 & (bus.halt == HALT_EBREAK)
                 & !(bus.ex_jal | bus.ex_jalr | bus.ex_branch);

  bht_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (fpc[IDX_W+1:2]),
    .rd_taken (pred),
    .wr_en    (bht_we),
    .wr_idx   (xpc[IDX_W+1:2]),
    .wr_taken (taken)
  );

  always_comb begin
    sel = SEL_SEQ;
    fl  = 1'b0;
    if (!run) begin
      sel = SEL_HOLD;
    end else if (bus.ex_valid & bus.ex_jalr) begin
      sel = SEL_JALR;
      fl  = 1'b1;
    end else if (bus.ex_valid & bus.ex_jal) begin
      sel = SEL_EXTGT;
      fl  = 1'b1;
    end else if (ex_br & taken & !bus.ex_pred_taken) begin
      sel = SEL_EXTGT;
      fl  = 1'b1;
    end else if (ex_br & !taken & bus.ex_pred_taken) begin
      sel = SEL_RECOV;
      fl  = 1'b1;
    end else if (bus.ex_valid & (bus.halt == HALT_EBREAK)) begin
      sel = SEL_HOLD;
    end else if (bus.if_valid & pred) begin
      sel = SEL_PRED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      unique case (state)
        ST_RUN:  if (halt_go) state <= ST_HALT;
        ST_HALT: if (bus.resume) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else if (bus.stat_clr) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (bht_we && br_q != '1)
        br_q <= br_q + 1'b1;
      if (mp && mp_q != '1)
        mp_q <= mp_q + 1'b1;
    end
  end

  assign bus.pred_taken = pred;
  assign bus.pc_sel     = sel;
  assign bus.flush      = fl;
  assign bus.halted     = (state == ST_HALT);
  assign bus.br_count   = br_q;
  assign bus.mp_count   = mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed steps plus random
// traffic against an operand-level reference model.
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int N     = 16;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  branch_predict_unit_if #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) bus ();

  branch_predict_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (N),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  int bht_m [N];
  int br_m;
  int mp_m;
  bit halted_m;

  logic [31:0] op_a;
  logic [31:0] op_b;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_taken(input logic [2:0] f);
    case (f)
      3'd0: return op_a == op_b;
      3'd1: return op_a != op_b;
      3'd4: return $signed(op_a) < $signed(op_b);
      3'd5: return $signed(op_a) >= $signed(op_b);
      3'd6: return op_a < op_b;
      3'd7: return op_a >= op_b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_ops(input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] d;
    op_a = a;
    op_b = b;
    d = a - b;
    bus.zero  = (a == b);
    bus.carry = (a >= b);
    bus.sign  = d[31];
    bus.over  = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  task automatic clear_in();
    bus.if_valid      = 0;
    bus.if_pc         = '0;
    bus.ex_valid      = 0;
    bus.ex_pc         = '0;
    bus.ex_branch     = 0;
    bus.ex_jal        = 0;
    bus.ex_jalr       = 0;
    bus.ex_funct      = '0;
    bus.ex_pred_taken = 0;
    bus.halt          = '0;
    bus.resume        = 0;
    bus.stat_clr      = 0;
    set_ops(32'd0, 32'd1);
  endtask

  task automatic set_br(input logic [31:0] pc,
                        input logic [2:0] f,
                        input bit ept);
    bus.ex_valid      = 1;
    bus.ex_pc         = pc;
    bus.ex_branch     = 1;
    bus.ex_funct      = f;
    bus.ex_pred_taken = ept;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) bht_m[i] = 1;
    br_m = 0;
    mp_m = 0;
    halted_m = 0;
  endtask

  task automatic eval_check(output bit mpc, output bit tk);
    bit pe, ev, br;
    int sel;
    bit fl;
    pe  = bht_m[idx(bus.if_pc)] >= 2;
    tk  = m_taken(bus.ex_funct);
    ev  = bus.ex_valid;
    br  = ev && bus.ex_branch;
    mpc = 0;
    fl  = 0;
    if (halted_m) sel = 0;
    else if (ev && bus.ex_jalr) begin sel = 1; fl = 1; end
    else if (ev && bus.ex_jal) begin sel = 3; fl = 1; end
    else if (br && tk && !bus.ex_pred_taken) begin
      sel = 3; fl = 1; mpc = 1;
    end else if (br && !tk && bus.ex_pred_taken) begin
      sel = 5; fl = 1; mpc = 1;
    end else if (ev && bus.halt == 3'b111) sel = 0;
    else if (bus.if_valid && pe) sel = 4;
    else sel = 2;
    chk("pred_taken", 32'(bus.pred_taken), 32'(pe));
    chk("pc_sel", 32'(bus.pc_sel), 32'(sel));
    chk("flush", 32'(bus.flush), 32'(fl));
    chk("halted", 32'(bus.halted), 32'(halted_m));
    chk("br_count", 32'(bus.br_count), 32'(br_m));
    chk("mp_count", 32'(bus.mp_count), 32'(mp_m));
  endtask

  task automatic update(input bit mpc, input bit tk);
    int k;
    bit ev, br, any;
    ev  = bus.ex_valid;
    br  = ev && bus.ex_branch;
    any = bus.ex_branch || bus.ex_jal || bus.ex_jalr;
    if (!halted_m && br) begin
      k = idx(bus.ex_pc);
      if (tk) bht_m[k] = (bht_m[k] < 3) ? bht_m[k] + 1 : 3;
      else    bht_m[k] = (bht_m[k] > 0) ? bht_m[k] - 1 : 0;
      if (br_m < MAXC) br_m++;
      if (mpc && mp_m < MAXC) mp_m++;
    end
    if (bus.stat_clr) begin
      br_m = 0;
      mp_m = 0;
    end
    if (halted_m) begin
      if (bus.resume) halted_m = 0;
    end else if (ev && bus.halt == 3'b111 && !any) begin
      halted_m = 1;
    end
  endtask

  task automatic step();
    bit mpc, tk;
    @(negedge clk);
    eval_check(mpc, tk);
    @(posedge clk);
    update(mpc, tk);
    #1;
  endtask

  task automatic enter_halt();
    clear_in();
    bus.ex_valid = 1;
    bus.halt     = 3'b111;
    step();
    clear_in();
  endtask

  initial begin
    bit r;
    n_cmp = 0;
    n_err = 0;
    rst_n = 0;
    clear_in();
    model_reset();
    #3;
    eval_check(r, r);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Any fetch after reset predicts not-taken.
    bus.if_valid = 1;
    bus.if_pc    = 32'h0000_1234;
    step();

    // Three taken BEQs at 0x40 predicted not-taken.
    clear_in();
    for (int i = 0; i < 3; i++) begin
      set_br(32'h40, 3'b000, 0);
      set_ops(32'd77, 32'd77);
      step();
    end
    clear_in();
    bus.if_valid = 1;
    bus.if_pc    = 32'h40;
    step();

    // Not-taken BGEU predicted taken: recovery.
    set_br(32'h40, 3'b111, 1);
    set_ops(32'd3, 32'd9);
    step();
    clear_in();
    bus.if_valid = 1;
    bus.if_pc    = 32'h40;
    step();

    // JALR wins over a mispredicted BNE.
    clear_in();
    set_br(32'h84, 3'b001, 0);
    bus.ex_jalr = 1;
    set_ops(32'd1, 32'd2);
    step();

    // EBREAK, branches while halted, resume.
    enter_halt();
    for (int i = 0; i < 3; i++) begin
      set_br(32'h40, 3'b000, 0);
      set_ops(32'd5, 32'd5);
      step();
    end
    clear_in();
    bus.resume = 1;
    step();
    clear_in();
    step();
    bus.resume = 1;
    step();

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      int sel;
      logic [31:0] a;
      clear_in();
      bus.if_valid = 1'($urandom);
      bus.if_pc    = $urandom;
      bus.ex_valid = ($urandom % 4) != 0;
      bus.ex_pc    = $urandom;
      sel = $urandom % 8;
      bus.ex_branch = (sel < 5) || ($urandom % 8 == 0);
      bus.ex_jal    = (sel == 5) || ($urandom % 10 == 0);
      bus.ex_jalr   = (sel == 6) || ($urandom % 10 == 0);
      bus.ex_funct  = 3'($urandom);
      if ($urandom % 4 == 0)
        bus.ex_pred_taken = 1'($urandom);
      else
        bus.ex_pred_taken = bht_m[idx(bus.ex_pc)] >= 2;
      if (!(bus.ex_branch || bus.ex_jal || bus.ex_jalr)
          && ($urandom % 12 == 0))
        bus.halt = 3'b111;
      else
        bus.halt = 3'($urandom % 7);
      bus.resume   = ($urandom % 3) == 0;
      bus.stat_clr = ($urandom % 40) == 0;
      a = $urandom;
      case ($urandom % 4)
        0: set_ops(a, a);
        1: set_ops(a, a ^ 32'h8000_0000);
        default: set_ops(a, $urandom);
      endcase
      step();
    end

    // Make sure we are running, then saturate br_count.
    clear_in();
    bus.resume   = 1;
    bus.stat_clr = 1;
    step();
    clear_in();
    for (int i = 0; i < MAXC + 2; i++) begin
      set_br(32'h100, 3'b000, 1);
      set_ops(32'd4, 32'd4);
      step();
    end
    chk("br_sat", 32'(bus.br_count), 32'(MAXC));

    // Clear beats a same-cycle mispredict increment.
    set_br(32'h100, 3'b000, 0);
    set_ops(32'd1, 32'd2);
    bus.ex_pred_taken = 1;
    bus.stat_clr = 1;
    step();
    clear_in();
    step();

    // Asynchronous reset while halted.
    enter_halt();
    step();
    rst_n = 0;
    #1;
    model_reset();
    eval_check(r, r);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    bus.if_valid = 1;
    bus.if_pc    = 32'h40;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the combinational branch decision logic. It resolves conditional branches, JAL and JALR in EX from ALU flags, and predicts conditional-branch direction at fetch with a table of 2-bit saturating counters. On a misprediction it issues a flush and a recovery PC select. It also holds the PC in a halt state on EBREAK and keeps saturating branch and mispredict statistics counters. It sits between the IF PC mux and the EX stage.

## Interface
- `XLEN`, 32: PC width.
- `BHT_ENTRIES`, 64: number of counters; must be a power of 2, at least 2. `IDX_W = log2(BHT_ENTRIES)`.
- `CNT_W`, 16: width of each statistics counter.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_valid` in 1: a fetch is presented this cycle.
- `if_pc` in XLEN: fetch PC.
- `pred_taken` out 1: prediction for `if_pc`, equal to counter[`if_pc[IDX_W+1:2]`] bit 1.
- `ex_valid` in 1: the EX instruction is valid.
- `ex_pc` in XLEN: PC of the EX instruction.
- `ex_branch` in 1: the EX instruction is a conditional branch.
- `ex_jal` in 1: the EX instruction is JAL.
- `ex_jalr` in 1: the EX instruction is JALR.
- `ex_funct` in 3: funct3 of the EX instruction.
- `ex_pred_taken` in 1: the prediction carried down the pipeline with the EX instruction.
- `carry`, `zero`, `over`, `sign` in 1 each: ALU flags from rs1 − rs2. `carry`=1 means no borrow.
- `halt` in 3: `3'b111` means EBREAK.
- `resume` in 1: leave the halt state.
- `stat_clr` in 1: synchronously clear both statistics counters.
- `pc_sel` out 3: next-PC select.
- `flush` out 1: kill the IF and ID stages.
- `halted` out 1: high in the HALT state.
- `br_count` out CNT_W: number of resolved conditional branches.
- `mp_count` out CNT_W: number of mispredicts.

## Operation
- `pc_sel` codes:
  - 000: hold PC.
  - 001: JALR target (rs1+imm).
  - 010: if_pc+4.
  - 011: EX target (pc+offset).
  - 100: IF predicted target.
  - 101: ex_pc+4 (recovery).
- Actual direction by `ex_funct`:
  - 000 BEQ: `zero`.
  - 001 BNE: `!zero`.
  - 100 BLT: `sign!=over`.
  - 101 BGE: `sign==over`.
  - 110 BLTU: `!carry`.
  - 111 BGEU: `carry`.
  - 010 and 011: not taken; the counter is still updated.
- Two states, RUN and HALT.
  - RUN → HALT: in RUN, `ex_valid` is high, `halt==3'b111`, and no jump or branch is active.
  - HALT → RUN: `resume` is high.
- Next-PC priority, evaluated combinationally each cycle; first match wins:
  1. HALT: `pc_sel`=000, `flush`=0.
  2. `ex_valid & ex_jalr`: `pc_sel`=001, `flush`=1.
  3. `ex_valid & ex_jal`: `pc_sel`=011, `flush`=1.
  4. `ex_valid & ex_branch`, taken and `!ex_pred_taken`: `pc_sel`=011, `flush`=1.
  5. `ex_valid & ex_branch`, not taken and `ex_pred_taken`: `pc_sel`=101, `flush`=1.
  6. `ex_valid & halt==3'b111`: `pc_sel`=000; enter HALT at the next edge.
  7. `if_valid & pred_taken`: `pc_sel`=100.
  8. Otherwise: `pc_sel`=010.
- If more than one of `ex_jal`, `ex_jalr` and `ex_branch` is high, the priority order above decides.
- BHT update: in RUN, with `ex_valid & ex_branch`, counter[`ex_pc[IDX_W+1:2]`] increments if taken and decrements if not, saturating at 3 and 0.
- Statistics counters:
  - `br_count` increments on each resolved conditional branch.
  - `mp_count` increments on cases 4 and 5.
  - Both saturate at all-ones.
  - `stat_clr` takes priority over increment.
- In HALT: no BHT or statistics updates.

## Timing
- Reset values:
  - Every counter = 2'b01 (weakly not-taken), so `pred_taken`=0.
  - State = RUN, `halted`=0.
  - `br_count`=0, `mp_count`=0.
  - `pc_sel`=010 and `flush`=0 when no inputs are asserted.
- `pred_taken`, `pc_sel` and `flush` are combinational from the current inputs and registered state. Latency is 0 cycles.
- BHT write takes effect at the next edge. A same-cycle read of the same index returns the old value; there is no bypass.
- `halted` rises one cycle after the EBREAK cycle. `resume` in HALT returns to RUN at the next edge, and that cycle still outputs `pc_sel`=000.
- If `resume` is asserted in RUN, it has no effect.
- `rst_n` low mid-halt or mid-update: immediate return to the reset values.

## Structure
- Shared package `branch_pkg` holds:
  - the `pc_sel` code constants;
  - the funct3 branch codes;
  - the RUN/HALT state encoding.
- One sub-module, `bht_table`, holds the counter array.
  - Ports: `clk`, `rst_n`, a read index, and a write enable with index and taken flag.
  - Read is asynchronous; write is synchronous and saturating.
- The top level holds the resolve/priority logic, the FSM and the statistics counters.

## Test plan
- Reset, then fetch any PC → `pred_taken`=0, `pc_sel`=010, counts 0.
- BEQ at `ex_pc`=0x40 with `zero`=1, `ex_pred_taken`=0 → `pc_sel`=011, `flush`=1, `mp_count`=1. Repeat twice more; then fetch 0x40 → `pred_taken`=1, `pc_sel`=100.
- Counter held at 3, then BGEU with `carry`=0 and `ex_pred_taken`=1 → `pc_sel`=101, `flush`=1. The counter drops to 2 and `pred_taken` stays 1.
- JALR and BNE asserted together → `pc_sel`=001, `flush`=1.
- `halt`=111 with `ex_valid` → `pc_sel`=000 that cycle, `halted`=1 the next cycle. Branches presented while halted leave all counters unchanged. `resume` → `halted`=0 one cycle later.
- Force `br_count` to all-ones → one more branch leaves it at all-ones. `stat_clr` asserted in the same cycle as an increment → both counts become 0.
